// File: rtl/reg_file_mc.sv
// reg_file_mc: DEPTH x WIDTH register file for the multicycle MIPS datapath.
// One write port, two registered read ports, optional hardwired-zero r0 and a
// one-word-per-cycle clear sequencer (busy high while sweeping).
// Optional feature macro: REG_FILE_BYPASS_EN (write-before-read forwarding).
module reg_file_mc #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             clr_req,
  output logic             busy
);

  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Value a read port captures at this edge for address a
  function automatic logic [WIDTH-1:0] rd_value(input logic [AW-1:0] a);
    if (!in_range(a) || is_zero_reg(a)) return '0;
`ifdef REG_FILE_BYPASS_EN
    // wr_en already excludes dropped writes and the hardwired zero register
    if (wr_en && (wa == a)) return wd;
`endif
    return mem[a];
  endfunction

  // Write is effective only when idle, in range and not targeting hardwired r0
  always_comb begin
    wr_en = we && !busy && in_range(wa) && !is_zero_reg(wa);
  end

  // Clear sequencer: IDLE -> SWEEP on clr_req, one word per cycle up to DEPTH-1
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (ptr == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array update: reset clears all, else an effective write or a sweep clear
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wa] <= wd;
    end else if (state == SWEEP) begin
      mem[ptr] <= '0;
    end
  end

  // Registered read ports
  always_ff @(posedge clk) begin
    if (reset) begin
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      rd1 <= rd_value(ra1);
      rd2 <= rd_value(ra2);
    end
  end

endmodule

// File: tb/tb_reg_file_mc.sv
// Directed testbench for reg_file_mc: main instance uses defaults (32x32,
// ZERO_REG=1); a second instance (DEPTH=5, ZERO_REG=0) covers an ordinary r0,
// out-of-range addresses and a non-power-of-two sweep length.
module tb_reg_file_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        clr_req;
  logic        busy;

  logic        we2;
  logic [2:0]  wa2;
  logic [31:0] wd2;
  logic [2:0]  ra1_2;
  logic [2:0]  ra2_2;
  logic [31:0] rd1_2;
  logic [31:0] rd2_2;
  logic        clr_req2;
  logic        busy2;

  int total = 0;
  int bad   = 0;
  int cnt;
  logic [31:0] exp_byp;

  always #5 clk = ~clk;

  reg_file_mc #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .clr_req(clr_req), .busy(busy)
  );

  reg_file_mc #(.WIDTH(32), .DEPTH(5), .ZERO_REG(0)) dut2 (
    .clk(clk), .reset(reset), .we(we2), .wa(wa2), .wd(wd2),
    .ra1(ra1_2), .ra2(ra2_2), .rd1(rd1_2), .rd2(rd2_2),
    .clr_req(clr_req2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; clr_req = 1'b0;
    we2 = 1'b0; wa2 = '0; wd2 = '0; ra1_2 = '0; ra2_2 = '0; clr_req2 = 1'b0;
    tick; tick;
    reset = 1'b0;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);

    // Reset clears a previously written word
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; tick;
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5; tick;
    check("pre_reset_r5", rd1, 32'hDEADBEEF);
    reset = 1'b1; tick;
    reset = 1'b0;
    check("reset2_rd1", rd1, 32'h0);
    check("reset2_rd2", rd2, 32'h0);
    check("reset2_busy", {31'b0, busy}, 32'h0);
    tick;
    check("post_reset_r5", rd1, 32'h0);

    // Basic write / read on both ports
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; tick;
    we = 1'b0; ra1 = 5'd7; ra2 = 5'd7; tick;
    check("basic_rd1", rd1, 32'h12345678);
    check("basic_rd2", rd2, 32'h12345678);

    // Hardwired zero register ignores writes
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; tick;
    we = 1'b0; ra1 = 5'd0; tick;
    check("zero_reg", rd1, 32'h0);

    // Same-edge write and read of r3
    we = 1'b1; wa = 5'd3; wd = 32'h11; tick;
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; ra1 = 5'd3; ra2 = 5'd3; tick;
    we = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h11;
`endif
    check("bypass_rd1", rd1, exp_byp);
    check("bypass_rd2", rd2, exp_byp);
    tick;
    check("after_write_r3", rd1, 32'hA5A5A5A5);

    // Fill r1..r31 with their index
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i); tick;
    end
    // Clear request together with a write to r9 (accepted, then cleared)
    we = 1'b1; wa = 5'd9; wd = 32'hBEEF; clr_req = 1'b1; tick;
    we = 1'b0; clr_req = 1'b0;
    check("clr_busy_start", {31'b0, busy}, 32'h1);
    cnt = 1;
    for (int c = 1; c <= 40; c++) begin
      we = 1'b0; clr_req = 1'b0;
      if (c == 5) clr_req = 1'b1;
      if (c == 10) begin we = 1'b1; wa = 5'd4; wd = 32'h99; end
      if (c == 12) begin ra1 = 5'd20; ra2 = 5'd2; end
      tick;
      if (c == 12) begin
        check("mid_sweep_old_r20", rd1, 32'd20);
        check("mid_sweep_cleared_r2", rd2, 32'h0);
      end
      if (busy) cnt++;
      else break;
    end
    we = 1'b0; clr_req = 1'b0;
    check("busy_cycles", 32'(cnt), 32'd32);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i); tick;
      check($sformatf("swept_rd1_r%0d", i), rd1, 32'h0);
      check($sformatf("swept_rd2_r%0d", 31 - i), rd2, 32'h0);
    end
    we = 1'b1; wa = 5'd6; wd = 32'h66; tick;
    we = 1'b0; ra1 = 5'd6; tick;
    check("write_resumes", rd1, 32'h66);

    // Reset in the middle of a sweep
    we = 1'b1; wa = 5'd30; wd = 32'h30; tick;
    we = 1'b0; clr_req = 1'b1; tick;
    clr_req = 1'b0;
    for (int c = 0; c < 9; c++) tick;
    check("mid_sweep_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1; tick;
    reset = 1'b0;
    check("reset_sweep_busy", {31'b0, busy}, 32'h0);
    tick; tick;
    check("reset_sweep_idle", {31'b0, busy}, 32'h0);
    ra1 = 5'd30; ra2 = 5'd6; tick;
    check("reset_sweep_r30", rd1, 32'h0);
    check("reset_sweep_r6", rd2, 32'h0);
    we = 1'b1; wa = 5'd2; wd = 32'h55; tick;
    we = 1'b0; ra1 = 5'd2; tick;
    check("reset_sweep_write", rd1, 32'h55);

    // Second instance: ordinary r0, out-of-range addresses, 5-word sweep
    we2 = 1'b1; wa2 = 3'd0; wd2 = 32'hFFFFFFFF; tick;
    we2 = 1'b1; wa2 = 3'd4; wd2 = 32'h44; tick;
    we2 = 1'b1; wa2 = 3'd6; wd2 = 32'h77; tick;
    we2 = 1'b0; ra1_2 = 3'd0; ra2_2 = 3'd4; tick;
    check("d2_r0_ordinary", rd1_2, 32'hFFFFFFFF);
    check("d2_r4", rd2_2, 32'h44);
    ra1_2 = 3'd6; ra2_2 = 3'd5; tick;
    check("d2_oor_r6", rd1_2, 32'h0);
    check("d2_oor_r5", rd2_2, 32'h0);
    clr_req2 = 1'b1; tick;
    clr_req2 = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy2) cnt++;
      else break;
      tick;
    end
    check("d2_busy_cycles", 32'(cnt), 32'd5);
    ra1_2 = 3'd0; ra2_2 = 3'd4; tick;
    check("d2_swept_r0", rd1_2, 32'h0);
    check("d2_swept_r4", rd2_2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
